im_loader: RTL

- Program loader: the write side of the 16 x 16-bit instruction memory.
- Takes a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes the words to consecutive instruction-memory addresses 0..DEPTH-1, then checks a trailing XOR checksum byte.
- Holds the core (PC/fetch) stalled via cpu_hold while a load is in progress.

---
 rtl/im_loader_pkg.sv | 23 ++
 rtl/im_loader_if.sv | 26 ++
 rtl/im_loader_csum.sv | 28 ++
 rtl/im_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader, instruction memory and PC blocks.
// State codes are plain vectors so older blocks can share the same encoding.
package im_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DATA_W         = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_HI = 3'd1;
  localparam logic [2:0] ST_LOAD_LO = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // The byte stream is big-endian: the first byte of each pair is the upper half.
  function automatic logic [DATA_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus.
// The loader uses the slave modport; a byte source / memory model uses master.
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/im_loader_csum.sv
// 8-bit XOR accumulator for the program-image checksum.
// Clear wins over enable so a restart never folds in a stray byte.
module im_loader_csum
  import im_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_csum
);

  logic [BYTE_W-1:0] r_csum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= '0;
    end else if (i_clr) begin
      r_csum <= '0;
    end else if (i_en) begin
      r_csum <= r_csum ^ i_byte;
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/im_loader.sv
// Program loader: assembles a big-endian byte stream into 16-bit words, writes them
// to instruction memory 0..DEPTH-1, verifies a trailing XOR checksum and stalls the core meanwhile.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
)(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  im_loader_if.slave      bus,
  output logic            o_cpu_hold,
  output logic            o_done,
  output logic            o_err,
  output logic [ADDR_W:0] o_word_count
);

  logic [2:0]        r_state;
  logic [BYTE_W-1:0] r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_im_we;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_word_count;

  logic              w_ready;
  logic              w_xfer;
  logic              w_restart;
  logic              w_csum_en;
  logic              w_last;
  logic [BYTE_W-1:0] w_csum;

  assign w_ready   = (r_state == ST_LOAD_HI) || (r_state == ST_LOAD_LO) || (r_state == ST_CHECK);
  assign w_xfer    = bus.byte_valid && w_ready;
  assign w_restart = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_csum_en = w_xfer && ((r_state == ST_LOAD_HI) || (r_state == ST_LOAD_LO));
  assign w_last    = (r_addr == ADDR_W'(DEPTH - 1));

  im_loader_csum u_csum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_restart),
    .i_en    (w_csum_en),
    .i_byte  (bus.byte_in),
    .o_csum  (w_csum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_im_we      <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_im_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state      <= ST_LOAD_HI;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_word_count <= '0;
          end
        end
        ST_LOAD_HI: begin
          if (w_xfer) begin
            r_hi    <= bus.byte_in;
            r_state <= ST_LOAD_LO;
          end
        end
        // im_we is raised on entry to WRITE so it is a clean registered pulse.
        ST_LOAD_LO: begin
          if (w_xfer) begin
            r_wdata <= pack_word(r_hi, bus.byte_in);
            r_im_we <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_word_count <= r_word_count + 1'b1;
          if (w_last) begin
            r_state <= ST_CHECK;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= ST_LOAD_HI;
          end
        end
        // A bad image keeps the core held so it never runs corrupt code.
        ST_CHECK: begin
          if (w_xfer) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
            if (bus.byte_in == w_csum) begin
              r_err      <= 1'b0;
              r_cpu_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.im_we      = r_im_we;
  assign bus.im_waddr   = r_addr;
  assign bus.im_wdata   = r_wdata;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_word_count   = r_word_count;

endmodule
